// File: rtl/camera_ctrl_fsm_pkg.sv
// rtl/camera_ctrl_fsm_pkg.sv - shared types, defaults and output decode for the camera sequencer
// Purpose: state encoding, exposure defaults and the per-state control word used by camera_ctrl_fsm.
// Ports: none (package).
package camera_ctrl_fsm_pkg;

  localparam int DEF_EXP_W     = 5;
  localparam int DEF_EXP_MIN   = 2;
  localparam int DEF_EXP_MAX   = 30;
  localparam int DEF_EXP_RESET = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXPOSE  = 3'd1,
    ST_R1_SEL  = 3'd2,
    ST_R1_CONV = 3'd3,
    ST_R1_REL  = 3'd4,
    ST_R2_SEL  = 3'd5,
    ST_R2_CONV = 3'd6,
    ST_R2_REL  = 3'd7
  } state_t;

  // Registered control word; reload drives the timer Initial strobe.
  typedef struct packed {
    logic reload;
    logic start;
    logic erase;
    logic expose;
    logic nre_1;
    logic nre_2;
    logic adc;
    logic busy;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{reload: 1'b0, start: 1'b0, erase: 1'b1, expose: 1'b0,
                                   nre_1: 1'b1, nre_2: 1'b1, adc: 1'b0, busy: 1'b0};

  // Every timed state spends its first cycle reloading the timer, then counts.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic entry);
    ctrl_t c;
    c = CTRL_RESET;
    if (s != ST_IDLE) begin
      c.erase  = 1'b0;
      c.busy   = 1'b1;
      c.reload = entry;
      c.start  = ~entry;
    end
    case (s)
      ST_EXPOSE:  c.expose = 1'b1;
      ST_R1_SEL:  c.nre_1 = 1'b0;
      ST_R1_CONV: begin
        c.nre_1 = 1'b0;
        c.adc   = 1'b1;
      end
      ST_R2_SEL:  c.nre_2 = 1'b0;
      ST_R2_CONV: begin
        c.nre_2 = 1'b0;
        c.adc   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/camera_ctrl_fsm_exp_time_reg.sv
// rtl/camera_ctrl_fsm_exp_time_reg.sv - exposure setting register with button edge detect
// Purpose: saturating up/down exposure register stepped by rising edges of the two buttons.
// Ports: clk, reset (sync, active high); enable (capture idle); inc, dec (button levels);
//        exp_time (current setting).
module camera_ctrl_fsm_exp_time_reg #(
  parameter int               EXP_W     = 5,
  parameter logic [EXP_W-1:0] EXP_MIN   = 5'd2,
  parameter logic [EXP_W-1:0] EXP_MAX   = 5'd30,
  parameter logic [EXP_W-1:0] EXP_RESET = 5'd15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             inc,
  input  logic             dec,
  output logic [EXP_W-1:0] exp_time
);

  logic inc_q;
  logic dec_q;
  logic inc_ev;
  logic dec_ev;

  assign inc_ev = inc & ~inc_q;
  assign dec_ev = dec & ~dec_q;

  // History regs track the buttons even while disabled, so a press made during a
  // capture does not turn into a late step once the sequencer returns to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      exp_time <= EXP_RESET;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      if (enable && inc_ev && !dec_ev && (exp_time < EXP_MAX)) begin
        exp_time <= exp_time + 1'b1;
      end else if (enable && dec_ev && !inc_ev && (exp_time > EXP_MIN)) begin
        exp_time <= exp_time - 1'b1;
      end
    end
  end

endmodule

// File: rtl/camera_ctrl_fsm.sv
// rtl/camera_ctrl_fsm.sv - capture sequencer for the camera pixel array, timer and ADC
// Purpose: runs IDLE -> EXPOSE -> two-row readout -> IDLE and owns the exposure setting.
// Ports: Clk, Reset (sync, active high); Init, Exp_increase, Exp_decrease (debounced buttons);
//        Ovf5, Ovf4 (timer overflow pulses); Initial, Start, Exp_time (to timer);
//        Erase, Expose, NRE_1, NRE_2, ADC (pixel array / converter); Busy (not idle).
module camera_ctrl_fsm
  import camera_ctrl_fsm_pkg::*;
#(
  parameter int               EXP_W     = DEF_EXP_W,
  parameter logic [EXP_W-1:0] EXP_MIN   = EXP_W'(DEF_EXP_MIN),
  parameter logic [EXP_W-1:0] EXP_MAX   = EXP_W'(DEF_EXP_MAX),
  parameter logic [EXP_W-1:0] EXP_RESET = EXP_W'(DEF_EXP_RESET)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  input  logic             Ovf5,
  input  logic             Ovf4,
  output logic             Initial,
  output logic             Start,
  output logic [EXP_W-1:0] Exp_time,
  output logic             Erase,
  output logic             Expose,
  output logic             NRE_1,
  output logic             NRE_2,
  output logic             ADC,
  output logic             Busy
);

  state_t state;
  state_t state_next;
  logic   entry;
  logic   init_q;
  logic   init_ev;
  logic   timer_live;
  logic   exp_enable;
  ctrl_t  ctrl_q;

  assign init_ev = Init & ~init_q;

  // Outputs trail the state by one register. entry is high in the cycle right after
  // a state change, while the outputs still show the previous state; nothing is
  // acted on then. Once settled, a timer overflow only counts while Start is high,
  // so an overflow in the reload cycle is dropped.
  assign timer_live = ctrl_q.start & ~entry;
  assign exp_enable = (state == ST_IDLE) & ~entry;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= ST_IDLE;
      entry  <= 1'b0;
      init_q <= 1'b0;
    end else begin
      state  <= state_next;
      entry  <= (state_next != state);
      init_q <= Init;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (!entry && init_ev) state_next = ST_EXPOSE;
      ST_EXPOSE:  if (timer_live && Ovf5) state_next = ST_R1_SEL;
      ST_R1_SEL:  if (timer_live && Ovf4) state_next = ST_R1_CONV;
      ST_R1_CONV: if (timer_live && Ovf4) state_next = ST_R1_REL;
      ST_R1_REL:  if (timer_live && Ovf4) state_next = ST_R2_SEL;
      ST_R2_SEL:  if (timer_live && Ovf4) state_next = ST_R2_CONV;
      ST_R2_CONV: if (timer_live && Ovf4) state_next = ST_R2_REL;
      ST_R2_REL:  if (timer_live && Ovf4) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ctrl_q <= CTRL_RESET;
    end else begin
      ctrl_q <= decode_ctrl(state, entry);
    end
  end

  assign Initial = ctrl_q.reload;
  assign Start   = ctrl_q.start;
  assign Erase   = ctrl_q.erase;
  assign Expose  = ctrl_q.expose;
  assign NRE_1   = ctrl_q.nre_1;
  assign NRE_2   = ctrl_q.nre_2;
  assign ADC     = ctrl_q.adc;
  assign Busy    = ctrl_q.busy;

  camera_ctrl_fsm_exp_time_reg #(
    .EXP_W    (EXP_W),
    .EXP_MIN  (EXP_MIN),
    .EXP_MAX  (EXP_MAX),
    .EXP_RESET(EXP_RESET)
  ) u_exp_time_reg (
    .clk     (Clk),
    .reset   (Reset),
    .enable  (exp_enable),
    .inc     (Exp_increase),
    .dec     (Exp_decrease),
    .exp_time(Exp_time)
  );

endmodule

// File: tb/tb_camera_ctrl_fsm.sv
// tb/tb_camera_ctrl_fsm.sv - self-checking bench for camera_ctrl_fsm
// Purpose: directed and random stimulus compared every cycle against a visible-state reference model.
// Ports: none (top-level bench).
module tb_camera_ctrl_fsm;

  localparam int M_IDLE = 0, M_EXPOSE = 1, M_R1_SEL = 2, M_R1_CONV = 3;
  localparam int M_R1_REL = 4, M_R2_SEL = 5, M_R2_CONV = 6, M_R2_REL = 7;

  logic       Clk = 1'b0;
  logic       Reset, Init, Exp_increase, Exp_decrease, Ovf5, Ovf4;
  logic       Initial, Start, Erase, Expose, NRE_1, NRE_2, ADC, Busy;
  logic [4:0] Exp_time;

  camera_ctrl_fsm dut (
    .Clk(Clk), .Reset(Reset), .Init(Init), .Exp_increase(Exp_increase),
    .Exp_decrease(Exp_decrease), .Ovf5(Ovf5), .Ovf4(Ovf4), .Initial(Initial),
    .Start(Start), .Exp_time(Exp_time), .Erase(Erase), .Expose(Expose),
    .NRE_1(NRE_1), .NRE_2(NRE_2), .ADC(ADC), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the state as seen on the outputs, cycles spent in it, and a
  // pending move that appears on the outputs one edge after it is accepted.
  int m_vis = M_IDLE, m_age = 0, m_tgt = M_IDLE, m_exp = 15;
  bit m_pend = 0;
  bit p_init = 0, p_inc = 0, p_dec = 0;
  bit b_init = 0, b_inc = 0, b_dec = 0;
  int adc_rises = 0, init_pulses = 0;
  bit adc_prev = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    bit timed;
    timed = (m_vis != M_IDLE);
    chk("initial", {7'd0, Initial}, {7'd0, timed && m_age == 0});
    chk("start",   {7'd0, Start},   {7'd0, timed && m_age >= 1});
    chk("erase",   {7'd0, Erase},   {7'd0, !timed});
    chk("expose",  {7'd0, Expose},  {7'd0, m_vis == M_EXPOSE});
    chk("nre_1",   {7'd0, NRE_1},   {7'd0, !(m_vis == M_R1_SEL || m_vis == M_R1_CONV)});
    chk("nre_2",   {7'd0, NRE_2},   {7'd0, !(m_vis == M_R2_SEL || m_vis == M_R2_CONV)});
    chk("adc",     {7'd0, ADC},     {7'd0, m_vis == M_R1_CONV || m_vis == M_R2_CONV});
    chk("busy",    {7'd0, Busy},    {7'd0, timed});
    chk("exp_time", {3'd0, Exp_time}, 8'(m_exp));
    chk("nre_excl", {7'd0, NRE_1 | NRE_2}, 8'd1);
  endtask

  task automatic step(input bit rst, input bit o5, input bit o4);
    bit trig;
    bit inc_ev, dec_ev;
    int t, nexp;
    Reset = rst; Ovf5 = o5; Ovf4 = o4;
    Init = b_init; Exp_increase = b_inc; Exp_decrease = b_dec;
    trig = 0; t = m_vis; nexp = m_exp;
    inc_ev = b_inc && !p_inc;
    dec_ev = b_dec && !p_dec;
    if (!m_pend) begin
      if (m_vis == M_IDLE) begin
        if (b_init && !p_init) begin trig = 1; t = M_EXPOSE; end
        if (inc_ev && !dec_ev) nexp = (m_exp < 30) ? m_exp + 1 : 30;
        else if (dec_ev && !inc_ev) nexp = (m_exp > 2) ? m_exp - 1 : 2;
      end else if (m_age >= 1) begin
        if (m_vis == M_EXPOSE && o5) begin trig = 1; t = M_R1_SEL; end
        else if (m_vis >= M_R1_SEL && o4) begin
          trig = 1;
          t = (m_vis == M_R2_REL) ? M_IDLE : m_vis + 1;
        end
      end
    end
    @(posedge Clk);
    if (rst) begin
      m_vis = M_IDLE; m_age = 0; m_pend = 0; m_exp = 15;
      p_init = 0; p_inc = 0; p_dec = 0;
    end else begin
      if (m_pend) begin
        m_vis = m_tgt; m_age = 0; m_pend = 0;
      end else begin
        m_age++;
        if (trig) begin m_tgt = t; m_pend = 1; end
      end
      m_exp = nexp;
      p_init = b_init; p_inc = b_inc; p_dec = b_dec;
    end
    #1;
    check_all();
    if (ADC === 1'b1 && !adc_prev) adc_rises++;
    adc_prev = (ADC === 1'b1);
    if (Initial === 1'b1) init_pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic press_init();
    b_init = 1; step(0, 0, 0);
    b_init = 0;
  endtask

  // Ovf5 early, then Ovf4 every 4 cycles: enough to drain a whole capture.
  task automatic run_capture(input int n);
    for (int i = 0; i < n; i++) step(0, i == 3, (i > 5) && (i % 4 == 0));
  endtask

  initial begin
    int saved_exp;
    bit reached;
    Reset = 1; Init = 0; Exp_increase = 0; Exp_decrease = 0; Ovf5 = 0; Ovf4 = 0;

    // 1: reset, Init latency, exposure then first readout step
    step(1, 0, 0); step(1, 0, 0);
    chk("t1_reset_erase", {7'd0, Erase}, 8'd1);
    chk("t1_reset_exp", {3'd0, Exp_time}, 8'd15);
    b_init = 1; step(0, 0, 0);
    chk("t1_lat1_expose", {7'd0, Expose}, 8'd0);
    step(0, 0, 0);
    chk("t1_lat2_expose", {7'd0, Expose}, 8'd1);
    chk("t1_lat2_initial", {7'd0, Initial}, 8'd1);
    step(0, 0, 0);
    chk("t1_initial_one_cycle", {7'd0, Initial}, 8'd0);
    b_init = 0;
    idle(8);
    step(0, 1, 0); step(0, 0, 0); step(0, 0, 0);
    chk("t1_r1_sel_nre1", {7'd0, NRE_1}, 8'd0);

    // 2: finish that capture, then a full clean capture
    for (int i = 0; i < 40; i++) step(0, 0, (i % 4) == 0);
    chk("t2a_idle", {7'd0, Busy}, 8'd0);
    adc_rises = 0; init_pulses = 0;
    press_init();
    run_capture(50);
    chk("t2_adc_pulses", 8'(adc_rises), 8'd2);
    chk("t2_initial_pulses", 8'(init_pulses), 8'd7);
    chk("t2_end_erase", {7'd0, Erase}, 8'd1);
    chk("t2_end_busy", {7'd0, Busy}, 8'd0);

    // 3: saturation from reset
    step(1, 0, 0);
    for (int i = 0; i < 20; i++) begin b_inc = 1; step(0, 0, 0); b_inc = 0; step(0, 0, 0); end
    chk("t3_sat_max", {3'd0, Exp_time}, 8'd30);
    for (int i = 0; i < 40; i++) begin b_dec = 1; step(0, 0, 0); b_dec = 0; step(0, 0, 0); end
    chk("t3_sat_min", {3'd0, Exp_time}, 8'd2);

    // 4: simultaneous buttons cancel, held button steps once
    b_inc = 1; step(0, 0, 0); b_inc = 0; step(0, 0, 0);
    chk("t4_one_up", {3'd0, Exp_time}, 8'd3);
    b_inc = 1; b_dec = 1; step(0, 0, 0); b_inc = 0; b_dec = 0; step(0, 0, 0);
    chk("t4_both", {3'd0, Exp_time}, 8'd3);
    b_inc = 1; idle(6); b_inc = 0; step(0, 0, 0);
    chk("t4_held", {3'd0, Exp_time}, 8'd4);

    // 5: buttons during a capture, Ovf5 in the reload cycle
    saved_exp = m_exp;
    press_init();
    step(0, 0, 0);
    chk("t5_entry_initial", {7'd0, Initial}, 8'd1);
    step(0, 1, 0);
    step(0, 0, 0); step(0, 0, 0);
    chk("t5_ovf5_entry_ignored", {7'd0, Expose}, 8'd1);
    b_init = 1; b_inc = 1; step(0, 0, 0); b_init = 0; b_inc = 0; step(0, 0, 0);
    b_dec = 1; step(0, 0, 0); b_dec = 0;
    for (int i = 0; i < 40; i++) begin
      b_init = (i == 12);
      step(0, i == 1, (i > 3) && (i % 4 == 0));
    end
    b_init = 0;
    idle(2);
    chk("t5_no_restart", {7'd0, Busy}, 8'd0);
    chk("t5_exp_kept", {3'd0, Exp_time}, 8'(saved_exp));

    // 6: reset in R2_CONV, then a normal capture
    b_inc = 1; step(0, 0, 0); b_inc = 0;
    press_init();
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      step(0, i == 3, (i > 5) && (i % 4 == 0));
      reached = (m_vis == M_R2_CONV) && !m_pend;
    end
    chk("t6_reach_r2conv", {7'd0, ADC & ~NRE_1}, 8'd0);
    chk("t6_r2conv_adc", {7'd0, ADC}, 8'd1);
    step(1, 0, 1);
    chk("t6_rst_busy", {7'd0, Busy}, 8'd0);
    chk("t6_rst_nre2", {7'd0, NRE_2}, 8'd1);
    chk("t6_rst_adc", {7'd0, ADC}, 8'd0);
    chk("t6_rst_exp", {3'd0, Exp_time}, 8'd15);
    adc_rises = 0;
    press_init();
    run_capture(50);
    chk("t6_recapture_adc", 8'(adc_rises), 8'd2);

    // random phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) b_init = ~b_init;
      if ($urandom_range(0, 3) == 0) b_inc = ~b_inc;
      if ($urandom_range(0, 3) == 0) b_dec = ~b_dec;
      step($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
